// File: rtl/tinyshfl.sv
// tinyshfl: iterative RV32 shfl/unshfl unit, one butterfly stage per clock.
module tinyshfl #(
  parameter bit FAST = 1'b0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        unshfl_i,
  input  logic [31:0] rs1_i,
  input  logic [3:0]  rs2_i,
  output logic [31:0] rd_o,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] x_q;
  logic [3:0]  ctl_q, ctl_d;
  logic        unshfl_q;
  logic [1:0]  stg_q;
  logic [1:0]  b;
  logic        last;
  function automatic logic [31:0] stage(input logic [31:0] x, input logic [1:0] k);
    logic [31:0] l, r;
    logic [4:0]  n;
    l = k == 2'd3 ? 32'h00ff0000 : k == 2'd2 ? 32'h0f000f00 : k == 2'd1 ? 32'h30303030 : 32'h44444444;
    r = k == 2'd3 ? 32'h0000ff00 : k == 2'd2 ? 32'h00f000f0 : k == 2'd1 ? 32'h0c0c0c0c : 32'h22222222;
    n = 5'd1 << k;
    return (x & ~(l | r)) | ((x << n) & l) | ((x >> n) & r);
  endfunction
  // b selects the control bit handled this edge; FAST jumps straight to the next set bit
  always_comb begin
    b = unshfl_q ? stg_q : ~stg_q;
    if (FAST) begin
      b = 2'd0;
      for (int i = 3; i >= 0; i--) if (unshfl_q && ctl_q[i]) b = 2'(i);
      for (int i = 0; i < 4; i++) if (!unshfl_q && ctl_q[i]) b = 2'(i);
    end
    ctl_d = ctl_q & ~(4'b1 << b);
    last  = FAST ? ctl_d == 4'd0 : stg_q == 2'd3;
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q  <= IDLE;
      x_q      <= '0;
      ctl_q    <= '0;
      unshfl_q <= 1'b0;
      stg_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != RUN && start_i) begin
        x_q      <= rs1_i;
        ctl_q    <= rs2_i;
        unshfl_q <= unshfl_i;
        stg_q    <= '0;
      end else if (state_q == RUN) begin
        x_q   <= ctl_q[b] ? stage(x_q, b) : x_q;
        ctl_q <= ctl_d;
        stg_q <= stg_q + 2'd1;
      end
    end
  always_comb
    state_d = state_q == RUN ? (last ? DONE : RUN) : start_i ? RUN : state_q;
  always_comb begin
    rd_o   = x_q;
    busy_o = state_q == RUN;
    done_o = state_q == DONE;
  end
endmodule

// File: tb/tb_tinyshfl.sv
// tb_tinyshfl: drives FAST=0 and FAST=1 instances in lockstep against an index-permutation model.
module tb_tinyshfl;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, unshfl = 1'b0;
  logic [31:0] rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic [31:0] rd0, rd1, exp_rd = '0, r, r2;
  logic        busy0, done0, busy1, done1;
  int          total = 0, bad = 0;

  tinyshfl #(.FAST(1'b0)) dut0 (.clock_i(clk), .reset_i(rst), .start_i(start), .unshfl_i(unshfl),
    .rs1_i(rs1), .rs2_i(rs2), .rd_o(rd0), .busy_o(busy0), .done_o(done0));
  tinyshfl #(.FAST(1'b1)) dut1 (.clock_i(clk), .reset_i(rst), .start_i(start), .unshfl_i(unshfl),
    .rs1_i(rs1), .rs2_i(rs2), .rd_o(rd1), .busy_o(busy1), .done_o(done1));

  always #5 clk = ~clk;

  // zip stage k exchanges bit-index digits k and k+1; unzip runs the stages in reverse order
  function automatic logic [31:0] model(input logic [31:0] x, input logic [3:0] c, input logic u);
    logic [31:0] y;
    int k, j;
    for (int s = 0; s < 4; s++) begin
      k = u ? s : 3 - s;
      if (c[k]) begin
        y = '0;
        for (int i = 0; i < 32; i++) begin
          j = i & ~((1 << k) | (1 << (k + 1)));
          j |= ((i >> k) & 1) << (k + 1);
          j |= ((i >> (k + 1)) & 1) << k;
          y[j] = x[i];
        end
        x = y;
      end
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (done0) chk("rd_fast0", rd0, exp_rd);
    if (done1) chk("rd_fast1", rd1, exp_rd);
    if ((busy0 && done0) || (busy1 && done1)) chk("busy_done_excl", {busy0, done0, busy1, done1}, 4'b0);
  end

  task automatic op(input logic u, input logic [31:0] x, input logic [3:0] c, input bit glitch,
                    output logic [31:0] res);
    int l0 = 0, l1 = 0;
    @(negedge clk);
    start = 1'b1; unshfl = u; rs1 = x; rs2 = c;
    @(posedge clk); #1;
    start = 1'b0; exp_rd = model(x, c, u);
    rs1 = $urandom; rs2 = 4'($urandom); unshfl = 1'($urandom);
    chk("accept_flags", {28'b0, busy0, done0, busy1, done1}, 32'b1010);
    for (int e = 1; e <= 8 && (l0 == 0 || l1 == 0); e++) begin
      if (glitch && e == 1) begin start = 1'b1; rs1 = 32'hdeadbeef; rs2 = 4'h1; unshfl = ~u; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done0 && l0 == 0) l0 = e;
      if (done1 && l1 == 0) l1 = e;
    end
    chk("latency_fast0", l0, 4);
    chk("latency_fast1", l1, c == 4'd0 ? 1 : $countones(c));
    chk("rd_agree", rd1, rd0);
    res = rd0;
  endtask

  initial begin
    chk("model_shfl_f", model(32'h0000ffff, 4'hf, 1'b0), 32'h55555555);
    chk("model_unshfl_f", model(32'h55555555, 4'hf, 1'b1), 32'h0000ffff);
    chk("model_shfl_8", model(32'h12345678, 4'h8, 1'b0), 32'h12563478);
    #2 rst = 1'b1;
    #1 chk("reset_state", {rd0[15:0], rd1[15:0]}, 32'b0);
    chk("reset_flags", {28'b0, busy0, done0, busy1, done1}, 32'b0);
    @(negedge clk) rst = 1'b0;
    op(1'b0, 32'h0000ffff, 4'hf, 1'b0, r);  chk("shfl_ffff", r, 32'h55555555);
    op(1'b1, 32'h55555555, 4'hf, 1'b0, r);  chk("unshfl_5555", r, 32'h0000ffff);
    op(1'b0, 32'h12345678, 4'h8, 1'b0, r);  chk("shfl_8", r, 32'h12563478);
    op(1'b0, 32'hcafef00d, 4'h0, 1'b0, r);  chk("ctl0_identity", r, 32'hcafef00d);
    op(1'b1, 32'h89abcdef, 4'h5, 1'b0, r);  chk("unshfl_5", r, model(32'h89abcdef, 4'h5, 1'b1));
    op(1'b0, 32'h12345678, 4'hf, 1'b1, r);  chk("busy_ignore", r, model(32'h12345678, 4'hf, 1'b0));
    // asynchronous reset in the middle of an operation
    @(negedge clk); start = 1'b1; unshfl = 1'b0; rs1 = 32'ha5a5a5a5; rs2 = 4'hf;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("midrun_rd0", rd0, 32'b0);
    chk("midrun_rd1", rd1, 32'b0);
    chk("midrun_flags", {28'b0, busy0, done0, busy1, done1}, 32'b0);
    @(negedge clk) rst = 1'b0;
    op(1'b0, 32'h0f0f1234, 4'h6, 1'b0, r);  chk("after_reset", r, model(32'h0f0f1234, 4'h6, 1'b0));
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] x;
      logic [3:0]  c;
      x = $urandom; c = 4'($urandom);
      op(1'b0, x, c, 1'b0, r);
      op(1'b1, r, c, 1'b0, r2);
      if (r2 !== x) chk("roundtrip", r2, x);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
